// File: rtl/combat_pkg.sv
// Shared types and constants for the two-tank round controller.
package combat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } round_state_e;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_TANK0 = 2'b01;
  localparam logic [1:0] WINNER_TANK1 = 2'b10;

  localparam int DEF_COUNTDOWN_FRAMES = 180;
  localparam int DEF_PAUSE_FRAMES     = 120;
  localparam int DEF_WIN_SCORE        = 5;

endpackage

// File: rtl/round_ctrl_frame_timer.sv
// 8-bit load/decrement frame counter; saturates at zero and flags it.
module frame_timer (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic [7:0] count_o,
  output logic       zero_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == 8'd0);

endmodule

// File: rtl/round_ctrl.sv
// Round sequencing for a two-tank game: start/abort keys, countdown, scoring,
// inter-hit pause and game-over detection.
module round_ctrl
  import combat_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
  parameter int PAUSE_FRAMES     = DEF_PAUSE_FRAMES,
  parameter int WIN_SCORE        = DEF_WIN_SCORE
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       hit0,
  input  logic       hit1,
  output logic [7:0] keycode_out,
  output logic       GReset,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [2:0] state,
  output logic [7:0] timer,
  output logic [1:0] winner
);

  localparam logic [7:0] CD_LOAD    = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES - 1);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

  round_state_e state_q, state_d;
  logic [3:0]   score0_q, score0_d;
  logic [3:0]   score1_q, score1_d;
  logic [1:0]   winner_q, winner_d;
  logic         greset_q, greset_d;
  logic [7:0]   prev_key_q;

  logic         tmr_load;
  logic [7:0]   tmr_load_val;
  logic         tmr_dec;
  logic [7:0]   tmr_count;
  logic         tmr_zero;

  logic         start_ev;
  logic         abort_ev;
  logic [3:0]   score0_inc;
  logic [3:0]   score1_inc;

  // Edge-detect Enter so a held key starts only one round.
  assign start_ev   = (keycode == KEY_ENTER) && (prev_key_q != KEY_ENTER);
  assign abort_ev   = (keycode == KEY_ESC);
  assign score0_inc = score0_q + 4'd1;
  assign score1_inc = score1_q + 4'd1;

  frame_timer u_frame_timer (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    score0_d     = score0_q;
    score1_d     = score1_q;
    winner_d     = winner_q;
    greset_d     = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = 8'd0;
    tmr_dec      = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (abort_ev) begin
          state_d = ST_IDLE;
        end else if (start_ev) begin
          state_d      = ST_COUNTDOWN;
          score0_d     = 4'd0;
          score1_d     = 4'd0;
          winner_d     = WINNER_NONE;
          greset_d     = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = CD_LOAD;
        end
      end

      ST_COUNTDOWN: begin
        if (abort_ev) begin
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_PLAY;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_PLAY: begin
        if (abort_ev) begin
          state_d = ST_IDLE;
        end else if (hit0 && !hit1) begin
          score1_d = score1_inc;
          if (score1_inc == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = WINNER_TANK1;
          end else begin
            state_d      = ST_PAUSE;
            tmr_load     = 1'b1;
            tmr_load_val = PAUSE_LOAD;
          end
        end else if (hit1 && !hit0) begin
          score0_d = score0_inc;
          if (score0_inc == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = WINNER_TANK0;
          end else begin
            state_d      = ST_PAUSE;
            tmr_load     = 1'b1;
            tmr_load_val = PAUSE_LOAD;
          end
        end else if (hit0 && hit1) begin
          // Mutual hit: nobody scores, but the round still pauses.
          state_d      = ST_PAUSE;
          tmr_load     = 1'b1;
          tmr_load_val = PAUSE_LOAD;
        end
      end

      ST_PAUSE: begin
        if (abort_ev) begin
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d      = ST_COUNTDOWN;
          greset_d     = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = CD_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tmr_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      score0_q   <= 4'd0;
      score1_q   <= 4'd0;
      winner_q   <= WINNER_NONE;
      greset_q   <= 1'b0;
      prev_key_q <= KEY_NONE;
    end else begin
      state_q    <= state_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
      winner_q   <= winner_d;
      greset_q   <= greset_d;
      prev_key_q <= keycode;
    end
  end

  assign keycode_out = (state_q == ST_PLAY) ? keycode : KEY_NONE;
  assign GReset      = greset_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign state       = state_q;
  assign timer       = tmr_count;
  assign winner      = winner_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed and randomized checks of round_ctrl against a frame-level game model.
`timescale 1ns/100ps
module tb_round_ctrl;
  import combat_pkg::*;

  localparam int CD = 3;
  localparam int P  = 2;
  localparam int W  = 2;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       hit0, hit1;
  logic [7:0] keycode_out;
  logic       GReset;
  logic [3:0] score0, score1;
  logic [2:0] state;
  logic [7:0] timer;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: phase, frames already spent in the timed phase, scores, winner.
  round_state_e m_st;
  int           m_age;
  int           m_s0, m_s1;
  logic [1:0]   m_win;
  logic         m_gr;
  logic [7:0]   m_prev;
  int           greset_seen;

  round_ctrl #(
    .COUNTDOWN_FRAMES (CD),
    .PAUSE_FRAMES     (P),
    .WIN_SCORE        (W)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .hit0        (hit0),
    .hit1        (hit1),
    .keycode_out (keycode_out),
    .GReset      (GReset),
    .score0      (score0),
    .score1      (score1),
    .state       (state),
    .timer       (timer),
    .winner      (winner)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_timer();
    if (m_st == ST_COUNTDOWN) return 8'(CD - 1 - m_age);
    if (m_st == ST_PAUSE)     return 8'(P - 1 - m_age);
    return 8'd0;
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_age = 0; m_s0 = 0; m_s1 = 0;
    m_win = 2'b00; m_gr = 1'b0; m_prev = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] key, input logic h0, input logic h1);
    bit start, abort;
    start = (key == 8'h28) && (m_prev != 8'h28);
    abort = (key == 8'h29);
    m_gr  = 1'b0;
    if (abort && m_st != ST_IDLE) begin
      m_st = ST_IDLE;
    end else begin
      case (m_st)
        ST_IDLE, ST_OVER:
          if (start) begin
            m_st = ST_COUNTDOWN; m_age = 0; m_s0 = 0; m_s1 = 0;
            m_win = 2'b00; m_gr = 1'b1;
          end
        ST_COUNTDOWN:
          if (m_age == CD - 1) m_st = ST_PLAY; else m_age++;
        ST_PLAY:
          if (h0 || h1) begin
            if (h0 && !h1) m_s1++;
            if (h1 && !h0) m_s0++;
            if (m_s0 == W)      begin m_st = ST_OVER; m_win = 2'b01; end
            else if (m_s1 == W) begin m_st = ST_OVER; m_win = 2'b10; end
            else                begin m_st = ST_PAUSE; m_age = 0; end
          end
        ST_PAUSE:
          if (m_age == P - 1) begin m_st = ST_COUNTDOWN; m_age = 0; m_gr = 1'b1; end
          else m_age++;
        default: m_st = ST_IDLE;
      endcase
    end
    m_prev = key;
  endtask

  task automatic check_all();
    chk("state",  8'(state),  8'(m_st));
    chk("timer",  timer,      exp_timer());
    chk("score0", 8'(score0), 8'(m_s0));
    chk("score1", 8'(score1), 8'(m_s1));
    chk("winner", 8'(winner), 8'(m_win));
    chk("GReset", 8'(GReset), 8'(m_gr));
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic [7:0] key, input logic h0, input logic h1, input bit show);
    keycode = key; hit0 = h0; hit1 = h1;
    #1;
    chk("keycode_out", keycode_out, (m_st == ST_PLAY) ? key : 8'h00);
    @(posedge frame_clk);
    model_edge(key, h0, h1);
    #1;
    check_all();
    if (GReset === 1'b1) greset_seen++;
    if (show)
      $display("step key=%02h h0=%0b h1=%0b -> state=%0d timer=%0d s0=%0d s1=%0d win=%0b grst=%0b",
               key, h0, h1, state, timer, score0, score1, winner, GReset);
  endtask

  task automatic do_reset();
    keycode = 8'h00; hit0 = 1'b0; hit1 = 1'b0;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    $display("reset asserted -> state=%0d timer=%0d s0=%0d s1=%0d win=%0b grst=%0b",
             state, timer, score0, score1, winner, GReset);
    @(negedge frame_clk);
    Reset = 1'b0;
    @(posedge frame_clk);
    model_edge(8'h00, 1'b0, 1'b0);
    #1;
    check_all();
  endtask

  initial begin
    do_reset();

    // Start, countdown 2,1,0, then PLAY on the fourth frame.
    step(8'h28, 0, 0, 1);
    chk("cd_state", 8'(state), 8'(ST_COUNTDOWN));
    chk("cd_greset", 8'(GReset), 8'd1);
    chk("cd_timer2", timer, 8'd2);
    step(8'h00, 0, 0, 1);
    chk("cd_timer1", timer, 8'd1);
    chk("cd_greset_low", 8'(GReset), 8'd0);
    step(8'h00, 0, 0, 1);
    chk("cd_timer0", timer, 8'd0);
    step(8'h00, 0, 0, 1);
    chk("play_state", 8'(state), 8'(ST_PLAY));

    // Key forwarding, then tank 0 struck.
    step(8'h04, 0, 0, 1);
    step(8'h00, 1, 0, 1);
    chk("hit0_score1", 8'(score1), 8'd1);
    chk("hit0_pause", 8'(state), 8'(ST_PAUSE));
    keycode = 8'h04; #1;
    chk("pause_keyout", keycode_out, 8'h00);
    step(8'h04, 0, 0, 1);
    step(8'h00, 0, 0, 1);
    chk("pause_to_cd", 8'(state), 8'(ST_COUNTDOWN));
    chk("pause_greset", 8'(GReset), 8'd1);
    for (int i = 0; i < CD; i++) step(8'h00, 0, 0, 1);
    step(8'h00, 1, 0, 1);
    chk("win_state", 8'(state), 8'(ST_OVER));
    chk("win_winner", 8'(winner), 8'b10);
    chk("win_score1", 8'(score1), 8'd2);

    // New game from OVER, then a mutual hit.
    step(8'h28, 0, 0, 1);
    for (int i = 0; i < CD; i++) step(8'h00, 0, 0, 1);
    step(8'h00, 1, 1, 1);
    chk("draw_state", 8'(state), 8'(ST_PAUSE));
    chk("draw_s0", 8'(score0), 8'd0);
    chk("draw_s1", 8'(score1), 8'd0);

    // Abort beats a simultaneous hit.
    for (int i = 0; i < P + CD; i++) step(8'h00, 0, 0, 1);
    step(8'h29, 0, 1, 1);
    chk("abort_state", 8'(state), 8'(ST_IDLE));
    chk("abort_s0", 8'(score0), 8'd0);

    // Held Enter yields one round start.
    greset_seen = 0;
    for (int i = 0; i < 10; i++) step(8'h28, 0, 0, 1);
    chk("held_enter_starts", 8'(greset_seen), 8'd1);
    step(8'h00, 1, 0, 1);
    step(8'h00, 0, 0, 1);
    chk("pre_reset_pause", 8'(state), 8'(ST_PAUSE));

    // Asynchronous reset in the middle of a PAUSE frame.
    #2;
    do_reset();

    // Randomized play against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [7:0] k;
      r = $urandom_range(0, 99);
      if (r < 15)      k = 8'h28;
      else if (r < 18) k = 8'h29;
      else if (r < 35) k = 8'h04;
      else if (r < 60) k = 8'h00;
      else             k = 8'($urandom_range(0, 255));
      step(k, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter COUNTDOWN_FRAMES, default 180, frames spent in COUNTDOWN (1..255).
REQ-002 Parameter PAUSE_FRAMES, default 120, frames spent in PAUSE after a hit (1..255).
REQ-003 Parameter WIN_SCORE, default 5, score that ends the game (1..15).
REQ-004 frame_clk  input  1  clock; Reset  input  1  asynchronous, active-high reset.
REQ-005 keycode  input  8  raw keyboard code, sampled on frame_clk.
REQ-006 hit0 / hit1  input  1 each  tank 0 / tank 1 struck this frame.
REQ-007 keycode_out  output  8  keycode forwarded to both tank instances.
REQ-008 GReset  output  1  one-frame tank reposition pulse.
REQ-009 score0 / score1  output  4 each  player scores.
REQ-010 state  output  3  current FSM state encoding.
REQ-011 timer  output  8  frames remaining in current COUNTDOWN/PAUSE.
REQ-012 winner  output  2  00 none, 01 tank 0, 10 tank 1.

Function
REQ-013 States: IDLE, COUNTDOWN, PLAY, PAUSE, OVER; all outputs except keycode_out registered.
REQ-014 start_ev = keycode==ENTER(8'h28) this frame and previous-frame keycode != 8'h28; abort_ev = keycode==ESC(8'h29).
REQ-015 IDLE or OVER + start_ev -> COUNTDOWN; scores and winner cleared, timer loaded COUNTDOWN_FRAMES-1, GReset=1 on first COUNTDOWN frame only.
REQ-016 COUNTDOWN: timer decrements by 1 per frame; frame where timer==0 -> PLAY next edge.
REQ-017 keycode_out = keycode combinationally while state==PLAY, else 8'h00.
REQ-018 PLAY, hit0 only: score1 += 1; hit1 only: score0 += 1; both: no score change (draw).
REQ-019 PLAY after any hit: new score == WIN_SCORE -> OVER with winner set; else -> PAUSE with timer loaded PAUSE_FRAMES-1.
REQ-020 PAUSE: timer decrements; at 0 -> COUNTDOWN with timer COUNTDOWN_FRAMES-1 and one-frame GReset; scores kept.
REQ-021 hit0/hit1 ignored in every state except PLAY.
REQ-022 abort_ev in COUNTDOWN, PLAY, PAUSE, OVER -> IDLE next edge; takes priority over simultaneous hit (no score change); scores retained until next start.
REQ-023 Held Enter produces exactly one start_ev; start_ev in COUNTDOWN/PLAY/PAUSE ignored.
REQ-024 Score arithmetic 4-bit unsigned; never exceeds WIN_SCORE.
REQ-025 timer reads 0 in IDLE, PLAY, OVER.

Reset
REQ-026 Reset asserted: state IDLE, score0=score1=0, timer=0, GReset=0, winner=00, previous-keycode register 8'h00, immediately and independent of frame_clk.
REQ-027 Reset mid-COUNTDOWN/PLAY/PAUSE abandons round; no GReset pulse generated by Reset itself.

Structure
REQ-028 Shared package combat_pkg holds state enum, KEY_ENTER, KEY_ESC, WINNER codes, parameter defaults.
REQ-029 One sub-module frame_timer: 8-bit load/decrement counter with zero flag, used for COUNTDOWN and PAUSE.

Verification (bench params COUNTDOWN_FRAMES=3, PAUSE_FRAMES=2, WIN_SCORE=2)
REQ-030 Reset, keycode 8'h28 one frame -> COUNTDOWN, GReset high one frame, timer 2,1,0, PLAY on 4th frame.
REQ-031 PLAY, keycode 8'h04 -> keycode_out 8'h04; same key in PAUSE -> 8'h00.
REQ-032 PLAY, hit0 one frame -> score1=1, PAUSE 2 frames, COUNTDOWN with GReset pulse; second hit0 in PLAY -> score1=2, OVER, winner=10.
REQ-033 PLAY, hit0 and hit1 same frame -> scores unchanged, PAUSE.
REQ-034 PLAY, hit1 with keycode 8'h29 same frame -> IDLE, score0 unchanged; Enter held 10 frames in IDLE -> single COUNTDOWN entry.
REQ-035 Reset pulsed during PAUSE -> all outputs at REQ-026 values before next frame_clk edge.
